// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types, funct3 encodings and decode helpers for the LSU.
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUS      = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } cause_e;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic logic f3_illegal(input logic store, input logic [2:0] f3, input logic rv64);
        return (f3 == 3'b111) ||
               (!rv64 && ((f3 == F3_D) || (f3 == F3_LWU))) ||
               (store && (f3[2:1] == 2'b11));
    endfunction

    // size is log2 of the access width in bytes
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            2'd1:    return lo[0];
            2'd2:    return lo[1:0] != 2'b00;
            2'd3:    return lo != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Byte-lane steering: store data/strobes and load extract/extend.
// Rev    : 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [ADDR_W-1:0] word_addr,
    output logic [XLEN-1:0]   lane_wdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   load_data
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int SH_W  = $clog2(XLEN);

    logic [OFF_W-1:0]       w_off;
    logic [SH_W-1:0]        w_lane_sh;
    logic [SH_W-1:0]        w_ext_sh;
    logic [BE_W-1:0]        w_be_base;
    logic [XLEN-1:0]        w_shifted;
    logic [XLEN-1:0]        w_left;
    logic signed [XLEN-1:0] w_sext;

    assign w_off      = addr[OFF_W-1:0];
    assign w_lane_sh  = {w_off, 3'b000};
    assign word_addr  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign lane_wdata = wdata << w_lane_sh;
    assign be         = w_be_base << w_off;
    assign w_shifted  = rdata >> w_lane_sh;

    // Extension: park the field at the MSB, then shift back arithmetically or logically
    always_comb begin
        w_be_base = '0;
        w_ext_sh  = '0;
        case (funct3[1:0])
            2'd0: begin w_be_base = BE_W'(8'h01); w_ext_sh = SH_W'(XLEN - 8);  end
            2'd1: begin w_be_base = BE_W'(8'h03); w_ext_sh = SH_W'(XLEN - 16); end
            2'd2: begin w_be_base = BE_W'(8'h0F); w_ext_sh = SH_W'(XLEN - 32); end
            default: begin w_be_base = BE_W'(8'hFF); w_ext_sh = '0; end
        endcase
    end

    assign w_left    = w_shifted << w_ext_sh;
    assign w_sext    = $signed(w_left) >>> w_ext_sh;
    assign load_data = funct3[2] ? (w_left >> w_ext_sh) : w_sext;

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : lsu
// Brief  : Single-outstanding load/store unit with req/gnt/rvalid memory port.
// Rev    : 1.0
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        rsp_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            r_state;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rd;
    logic              r_drop;
    logic [TO_W-1:0]   r_cnt;
    logic [4:0]        r_rsp_rd;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;
    cause_e            r_rsp_cause;

    logic [ADDR_W-1:0] w_word_addr;
    logic [XLEN-1:0]   w_lane_wdata;
    logic [XLEN/8-1:0] w_be;
    logic [XLEN-1:0]   w_load_data;
    logic              w_accept;
    logic              w_illegal;
    logic              w_misaligned;
    logic              w_done;
    logic              w_timeout;
    logic              w_bus_err;

    lsu_align #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) u_align (
        .addr       (r_addr),
        .funct3     (r_funct3),
        .wdata      (r_wdata),
        .rdata      (mem_rdata),
        .word_addr  (w_word_addr),
        .lane_wdata (w_lane_wdata),
        .be         (w_be),
        .load_data  (w_load_data)
    );

    assign req_ready    = (r_state == IDLE) && !flush;
    assign rsp_valid    = (r_state == RESP);
    assign mem_req      = (r_state == REQ);
    assign mem_we       = mem_req && r_store;
    assign mem_addr     = mem_req ? w_word_addr  : '0;
    assign mem_wdata    = mem_req ? w_lane_wdata : '0;
    assign mem_be       = mem_req ? w_be         : '0;
    assign rsp_rd       = r_rsp_rd;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign rsp_cause    = r_rsp_cause;

    assign w_accept     = req_valid && req_ready;
    assign w_illegal    = f3_illegal(req_store, req_funct3, XLEN == 64);
    assign w_misaligned = misaligned(req_funct3[1:0], req_addr[2:0]);
    assign w_done       = mem_rvalid && (((r_state == REQ) && mem_gnt) || (r_state == WAIT));
    assign w_timeout    = (TIMEOUT != 0) && (r_cnt == TO_W'(TIMEOUT - 1));
    assign w_bus_err    = !w_done || mem_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_store     <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= '0;
            r_drop      <= 1'b0;
            r_cnt       <= '0;
            r_rsp_rd    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rd     <= req_rd;
                        r_drop   <= 1'b0;
                        r_cnt    <= '0;
                        // Decode errors answer directly and never touch the bus
                        if (w_illegal || w_misaligned) begin
                            r_state     <= RESP;
                            r_rsp_rd    <= req_store ? 5'd0 : req_rd;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_cause <= w_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        end else begin
                            r_state <= REQ;
                        end
                    end
                end
                REQ, WAIT: begin
                    if ((r_state == REQ) && flush && !mem_gnt) begin
                        r_state <= IDLE;
                    end else if (w_done || w_timeout) begin
                        if (r_drop || flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_state     <= RESP;
                            r_rsp_rd    <= r_store ? 5'd0 : r_rd;
                            r_rsp_err   <= w_bus_err;
                            r_rsp_cause <= w_bus_err ? CAUSE_BUS : CAUSE_NONE;
                            r_rsp_rdata <= (w_bus_err || r_store) ? '0 : w_load_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (flush) begin
                            r_drop <= 1'b1;
                        end
                        if ((r_state == REQ) && mem_gnt) begin
                            r_state <= WAIT;
                        end
                    end
                end
                RESP: begin
                    if (flush || rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
